// File: rtl/fir_tap_sequencer.sv
// Sequences one FIR output: on each accepted sample, streams NTAPS (sample, coefficient)
// operand pairs, newest sample first, to a downstream MAC stage.
module fir_tap_sequencer #(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [DW-1:0]            coef_data,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    output logic [DW-1:0]            X,
    output logic [DW-1:0]            B,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic                     mac_last
);

    localparam int unsigned AW = $clog2(NTAPS);
    localparam logic [AW-1:0] LastTap = AW'(NTAPS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q;
    logic [DW-1:0] delay_q [NTAPS];
    logic [DW-1:0] coef_q  [NTAPS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] newest_q;
    logic [AW-1:0] k_q;

    logic [AW-1:0] k_nxt;
    logic [AW-1:0] tap_idx;
    logic          accept;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign k_nxt    = k_q + 1'b1;
    // Delay line is read backwards from the newest sample; AW-bit subtraction wraps mod NTAPS.
    assign tap_idx  = newest_q - k_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            newest_q <= '0;
            k_q      <= '0;
            X        <= '0;
            B        <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (coef_we) begin
                        coef_q[coef_addr] <= coef_data;
                    end
                    if (accept) begin
                        delay_q[wr_ptr_q] <= in_data;
                        newest_q          <= wr_ptr_q;
                        wr_ptr_q          <= wr_ptr_q + 1'b1;
                        k_q               <= '0;
                        state_q           <= StRun;
                        // Tap 0 bypasses both stores so this cycle's writes are seen immediately.
                        X        <= in_data;
                        B        <= (coef_we && coef_addr == '0) ? coef_data : coef_q[0];
                        mac_en   <= 1'b1;
                        mac_clr  <= 1'b1;
                        mac_last <= 1'b0;
                    end else begin
                        X        <= '0;
                        B        <= '0;
                        mac_en   <= 1'b0;
                        mac_clr  <= 1'b0;
                        mac_last <= 1'b0;
                    end
                end
                StRun: begin
                    if (k_q == LastTap) begin
                        state_q  <= StIdle;
                        k_q      <= '0;
                        X        <= '0;
                        B        <= '0;
                        mac_en   <= 1'b0;
                        mac_clr  <= 1'b0;
                        mac_last <= 1'b0;
                    end else begin
                        k_q      <= k_nxt;
                        X        <= delay_q[tap_idx];
                        B        <= coef_q[k_nxt];
                        mac_en   <= 1'b1;
                        mac_clr  <= 1'b0;
                        mac_last <= (k_nxt == LastTap);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (NTAPS=4, DW=16) against an array-based
// model of the delay line and coefficient store.
module tb_fir_tap_sequencer;

    localparam int NT = 4;
    localparam int DWD = 16;
    localparam int AWD = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           coef_we;
    logic [AWD-1:0] coef_addr;
    logic [DWD-1:0] coef_data;
    logic           in_valid;
    logic [DWD-1:0] in_data;
    logic           in_ready;
    logic [DWD-1:0] X;
    logic [DWD-1:0] B;
    logic           mac_en;
    logic           mac_clr;
    logic           mac_last;

    int checks = 0;
    int errors = 0;

    logic [DWD-1:0] delay_m [NT];
    logic [DWD-1:0] coef_m  [NT];
    int             wr_m;

    fir_tap_sequencer #(.NTAPS(NT), .DW(DWD)) dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .X         (X),
        .B         (B),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_last  (mac_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            delay_m[i] = '0;
            coef_m[i]  = '0;
        end
        wr_m = 0;
    endtask

    // Offers sample d, optionally with a same-cycle coefficient write, then checks every tap.
    // cw_run issues coef[0]=7 during the run (must be ignored); hold_valid keeps in_valid high
    // with d_next on the bus while the block is busy (must be ignored too).
    task automatic drive_sample(input logic [DWD-1:0] d, input bit cw, input logic [AWD-1:0] ca,
                                input logic [DWD-1:0] cd, input bit cw_run, input bit hold_valid,
                                input logic [DWD-1:0] d_next);
        int n;
        int newest;
        logic [DWD-1:0] ex;
        logic [DWD-1:0] eb;
        in_data  = d;
        in_valid = 1'b1;
        coef_we  = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (cw) begin
            coef_we   = 1'b1;
            coef_addr = ca;
            coef_data = cd;
            coef_m[ca] = cd;
        end
        delay_m[wr_m] = d;
        newest = wr_m;
        wr_m = (wr_m + 1) % NT;
        tick();
        coef_we = 1'b0;
        if (hold_valid) in_data = d_next;
        else in_valid = 1'b0;
        for (int k = 0; k < NT; k++) begin
            ex = delay_m[(newest - k + NT) % NT];
            eb = coef_m[k];
            checks++;
            if (X !== ex) begin
                errors++;
                $display("FAIL tap_x k=%0d: X=%0d required %0d", k, X, ex);
            end
            checks++;
            if (B !== eb) begin
                errors++;
                $display("FAIL tap_b k=%0d: B=%0d required %0d", k, B, eb);
            end
            checks++;
            if ({mac_en, mac_clr, mac_last, in_ready} !== {1'b1, k == 0, k == NT - 1, 1'b0}) begin
                errors++;
                $display("FAIL tap_ctl k=%0d: en/clr/last/rdy=%b%b%b%b required 1%b%b0",
                         k, mac_en, mac_clr, mac_last, in_ready, k == 0, k == NT - 1);
            end
            if (cw_run && k == 0) begin
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = 16'd7;
            end
            tick();
            coef_we = 1'b0;
        end
        checks++;
        if ({in_ready, mac_en, mac_clr, mac_last} !== 4'b1000 || X !== '0 || B !== '0) begin
            errors++;
            $display("FAIL run_end: rdy/en/clr/last=%b%b%b%b X=%0d B=%0d required 1000 X=0 B=0",
                     in_ready, mac_en, mac_clr, mac_last, X, B);
        end
    endtask

    task automatic load_coefs(input logic [DWD-1:0] c0, input logic [DWD-1:0] c1,
                              input logic [DWD-1:0] c2, input logic [DWD-1:0] c3);
        logic [DWD-1:0] c [NT];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < NT; i++) begin
            coef_we   = 1'b1;
            coef_addr = AWD'(i);
            coef_data = c[i];
            coef_m[i] = c[i];
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, mac_en, mac_clr, mac_last} !== 4'b1000 || X !== '0 || B !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: rdy/en/clr/last=%b%b%b%b X=%0d B=%0d required 1000 0 0",
                         i, in_ready, mac_en, mac_clr, mac_last, X, B);
            end
            tick();
        end
    endtask

    task automatic test_single();
        load_coefs(16'd1, 16'd2, 16'd3, 16'd4);
        drive_sample(16'd100, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [DWD-1:0] v [5];
        v[0] = 16'd10; v[1] = 16'd20; v[2] = 16'd30; v[3] = 16'd40; v[4] = 16'd50;
        for (int i = 0; i < 5; i++)
            drive_sample(v[i], 1'b0, '0, '0, 1'b0, i < 4, (i < 4) ? v[(i + 1) % 5] : '0);
    endtask

    task automatic test_coef_write();
        drive_sample(16'd11, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        drive_sample(16'd12, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive_sample(16'd13, 1'b1, '0, 16'd7, 1'b0, 1'b0, '0);
    endtask

    task automatic test_rst_abort();
        in_data  = 16'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        coef_we  = 1'b1;
        coef_addr = 2'd1;
        coef_data = 16'd99;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        model_reset();
        for (int i = 0; i < NT; i++) begin
            checks++;
            if ({in_ready, mac_en, mac_last} !== 3'b100) begin
                errors++;
                $display("FAIL rst_abort cyc=%0d: rdy/en/last=%b%b%b required 100",
                         i, in_ready, mac_en, mac_last);
            end
            tick();
        end
        drive_sample(16'd5, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1) begin
                    coef_we   = 1'b1;
                    coef_addr = AWD'($urandom_range(0, NT - 1));
                    coef_data = DWD'($urandom);
                    coef_m[coef_addr] = coef_data;
                end
                tick();
                coef_we = 1'b0;
            end
            drive_sample(DWD'($urandom), $urandom_range(0, 1) == 1, AWD'($urandom_range(0, NT - 1)),
                         DWD'($urandom), $urandom_range(0, 1) == 1, 1'b0, '0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_coef_write();
        test_rst_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
